// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq
//   Sequential BCD-to-binary converter using reverse double-dabble: each
//   clock shifts the {bcd, bin} register right by one. It then subtracts 3
//   from every BCD digit that is 8 or more. After BIN_W iterations the bin
//   field holds the binary value. Malformed digits are rejected at capture.
//   Results above MAX_VAL saturate.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      conversion request, sampled only in IDLE
//   bcd_in     packed BCD operand, most significant digit in the top nibble
//   busy       high while iterating
//   done       one-cycle pulse when binary_out and the flags are valid
//   binary_out converted (possibly saturated) value
//   digit_err  a captured nibble was greater than 9
//   range_err  the converted value exceeded MAX_VAL
//
// state   | meaning
// IDLE    | waiting for start
// CONVERT | one shift/adjust iteration per cycle, BIN_W cycles
// DONE    | result valid, done pulse, back to IDLE
module bcd_to_binary_seq #(
  parameter int DIGITS  = 3,
  parameter int BIN_W   = 10,
  parameter int MAX_VAL = 511
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      binary_out,
  output logic                  digit_err,
  output logic                  range_err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_shift;
  logic [SR_W-1:0]  sr_next;
  logic [BIN_W-1:0] bin_next;
  logic             bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Shift first, then correct each digit: a digit that received a carried-in
  // MSB (worth 8 after the shift) really represents 5, hence the -3.
  always_comb begin
    sr_shift = sr >> 1;
    sr_next  = sr_shift;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_shift[BIN_W + 4*i +: 4] >= 4'd8)
        sr_next[BIN_W + 4*i +: 4] = sr_shift[BIN_W + 4*i +: 4] - 4'd3;
    end
    bin_next = sr_next[BIN_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sr         <= '0;
      binary_out <= '0;
      digit_err  <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (bad_digit) begin
              digit_err  <= 1'b1;
              range_err  <= 1'b0;
              binary_out <= '0;
              state      <= DONE;
            end else begin
              sr        <= {bcd_in, {BIN_W{1'b0}}};
              cnt       <= '0;
              digit_err <= 1'b0;
              range_err <= 1'b0;
              state     <= CONVERT;
            end
          end
        end
        CONVERT: begin
          sr  <= sr_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= DONE;
            if (bin_next > MAX_BIN) begin
              binary_out <= MAX_BIN;
              range_err  <= 1'b1;
            end else begin
              binary_out <= bin_next;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == CONVERT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
module tb_bcd_to_binary_seq;

  localparam int DIGITS  = 3;
  localparam int BIN_W   = 10;
  localparam int MAX_VAL = 511;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [4*DIGITS-1:0] bcd_in = '0;
  logic                busy, done, digit_err, range_err;
  logic [BIN_W-1:0]    binary_out;

  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic             derr;
    logic             rerr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp    = 0;
  int   n_err    = 0;
  int   n_done   = 0;
  int   n_pushed = 0;

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W), .MAX_VAL(MAX_VAL)) dut (
    .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .binary_out(binary_out),
    .digit_err(digit_err), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: decimal value of the nibbles, then validate and saturate.
  function automatic exp_t model(input logic [4*DIGITS-1:0] v);
    exp_t e;
    int   val = 0;
    logic bad = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
      val = val * 10 + int'(v[4*i +: 4]);
    end
    e.derr = bad;
    e.rerr = 1'b0;
    if (bad) e.bin = '0;
    else if (val > MAX_VAL) begin
      e.bin  = BIN_W'(MAX_VAL);
      e.rerr = 1'b1;
    end else e.bin = BIN_W'(val);
    return e;
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      n_done++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("binary_out", 32'(binary_out), 32'(e.bin));
        chk("digit_err", 32'(digit_err), 32'(e.derr));
        chk("range_err", 32'(range_err), 32'(e.rerr));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Called just after a rising edge; returns just after the rising edge that
  // follows the done cycle. disturb re-pulses start and scrambles bcd_in.
  task automatic run(input logic [4*DIGITS-1:0] v, input bit disturb);
    exp_t e;
    int   lat = 0;
    int   busyc = 0;
    int   flagbad = 0;
    e = model(v);
    exp_q.push_back(e);
    n_pushed++;
    start  = 1'b1;
    bcd_in = v;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        busyc++;
        if (digit_err !== 1'b0 || range_err !== 1'b0) flagbad++;
      end
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (disturb) begin
        if (k == 2) bcd_in = 12'h777;
        if (k == 4) begin start = 1'b1; bcd_in = 12'h456; end
        if (k == 5) start = 1'b0;
        if (k == 6) bcd_in = 12'h888;
      end
    end
    chk($sformatf("latency_%03h", v), 32'(lat), e.derr ? 32'd1 : 32'(BIN_W + 1));
    chk($sformatf("busy_cycles_%03h", v), 32'(busyc), e.derr ? 32'd0 : 32'(BIN_W));
    chk($sformatf("flags_clear_while_busy_%03h", v), 32'(flagbad), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_binary_out", 32'(binary_out), 32'd0);
    chk("rst_flags", 32'({digit_err, range_err}), 32'd0);
    @(posedge clk); #1;

    run(12'h359, 1'b0);
    run(12'h000, 1'b0);
    run(12'h511, 1'b0);
    run(12'h512, 1'b0);
    run(12'h999, 1'b0);

    // Result must stay put while idle.
    repeat (3) @(negedge clk);
    chk("hold_binary_out", 32'(binary_out), 32'(MAX_VAL));
    chk("hold_range_err", 32'(range_err), 32'd1);
    @(posedge clk); #1;

    run(12'h0A5, 1'b0);
    run(12'h123, 1'b1);
    repeat (15) @(posedge clk);
    #1;

    // Abort mid-conversion: no done, everything cleared.
    start  = 1'b1;
    bcd_in = 12'h300;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_binary_out", 32'(binary_out), 32'd0);
    chk("abort_flags", 32'({digit_err, range_err}), 32'd0);
    repeat (15) @(posedge clk);
    #1;
    run(12'h007, 1'b0);

    // Back-to-back: start in the cycle right after done.
    run(12'h042, 1'b0);
    run(12'h987, 1'b0);
    run(12'h250, 1'b0);

    repeat (15) @(posedge clk);
    chk("done_count", 32'(n_done), 32'(n_pushed));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
Sequential BCD-to-binary converter. It uses reverse double-dabble: shift right, then subtract 3 from each BCD digit that is 8 or more, one iteration per clock. It converts operator-entered decimal values (heading offset, calibration target from the switch/button keypad path) into binary for the compass arithmetic. It validates each digit and saturates results above MAX_VAL.

Parameters:
DIGITS, 3, number of BCD digits in bcd_in (most significant digit in the top nibble)
BIN_W, 10, width of binary_out and the iteration count; 2^BIN_W must exceed 10^DIGITS-1
MAX_VAL, 511, largest legal result; larger results saturate to this value

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a conversion; sampled only in IDLE
bcd_in  in  4*DIGITS  packed BCD operand {hundreds,tens,ones}; captured on the accepted start cycle only
busy  out  1  high while converting
done  out  1  one-cycle pulse when the result and flags are valid
binary_out  out  BIN_W  converted value; held until the next accepted start
digit_err  out  1  a captured nibble was greater than 9; held until the next accepted start
range_err  out  1  converted value was greater than MAX_VAL; held until the next accepted start

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.
- Reset (rst high at a clk edge):
  - state goes to IDLE; iteration counter to 0; internal shift register to 0.
  - busy=0, done=0, binary_out=0, digit_err=0, range_err=0.
  - rst takes priority over every other input, including in the middle of a conversion. No partial result is ever published.
- States: IDLE, CONVERT, DONE.
- IDLE:
  - start=1 in cycle T with a valid operand: capture bcd_in into the upper 4*DIGITS bits of a {bcd, bin} register. Clear the bin field, counter=0, clear both error flags, go to CONVERT.
  - start=1 in cycle T with any nibble greater than 9: digit_err=1, range_err=0, binary_out=0, go to DONE. done pulses in T+1.
- CONVERT (cycles T+1 through T+BIN_W), one iteration per cycle:
  - Shift the whole {bcd, bin} register right by 1; the bcd LSB enters the bin MSB.
  - Then subtract 3 from every bcd digit that is 8 or more.
  - Increment the counter; after the iteration with counter=BIN_W-1, go to DONE.
  - busy=1 for exactly BIN_W cycles.
  - start is ignored while busy. bcd_in changes after capture have no effect.
- Entry to DONE (edge ending T+BIN_W):
  - If bin is greater than MAX_VAL: binary_out=MAX_VAL, range_err=1. Otherwise binary_out=bin.
- DONE (cycle T+BIN_W+1):
  - done=1 and busy=0 for this single cycle, then return to IDLE.
  - start is ignored in DONE. The earliest next accepted start is the following cycle.
  - Latency from start to done: BIN_W+1 cycles; 11 at the defaults.
- Comparisons are unsigned. The bcd field is zero after the final iteration.
- Outputs change only at the edges described above.

Test Plan:
- Reset, then start with bcd_in=0x359 at cycle T -> busy high T+1..T+10; done=1 at T+11; binary_out=359; both error flags 0.
- Boundary values, each run separately: 0x000 -> 0; 0x511 -> 511 with range_err=0; 0x512 -> 511 with range_err=1; 0x999 -> 511 with range_err=1.
- bcd_in=0x0A5 with start -> done at T+1; digit_err=1; binary_out=0; busy never asserted.
- Start with 0x123; pulse start with 0x456 at T+4; change bcd_in during CONVERT -> done at T+11 only; binary_out=123; no second done.
- Start with 0x300; assert rst at T+5 -> next cycle busy=0 and all outputs 0; no done pulse. A new start with 0x007 -> 7 after 11 cycles.
- Back-to-back: start in the cycle after done -> accepted; done again 11 cycles later. Earlier results are held stable in between.
